hazard_sequencer: RTL
=====================

Name: hazard_sequencer

Overview:
- Central hazard/sequencing controller for the 5-stage pipeline. Drives the hazard fields of the pipeline interface: pc_write, if_id_write, stall, forwardA, forwardB. Also drives per-latch write and flush enables for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves, in priority order: memory wait, control redirect, load-use, instruction-fetch wait.
- Sequences program halt: front end drains, then the pipeline freezes permanently.
- Counts stall cycles for performance reporting.

Parameters:
- CNT_W, 32, width of the stall-cycle counter; saturates at all-ones.
- DRAIN_MAX, 7, maximum cycles in DRAIN before forced HALTED with drain_err.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- ihit  in  1  imem returned the instruction this cycle
- dhit  in  1  dmem access completed this cycle
- mem_dreq  in  1  load or store present in MEM stage
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_use1, id_use2  in  1 each  ID instruction reads rs1 / rs2
- id_halt  in  1  HALT decoded in ID
- ex_rs1, ex_rs2  in  5 each  source registers in EX (id_ex latch)
- ex_rd  in  5  id_ex_rd
- ex_load  in  1  id_ex_memtoreg
- ex_redirect  in  1  branch taken or jump resolved in EX
- mem_rd  in  5  ex_mem_rd
- mem_regwrite  in  1  ex_mem_regwrite
- wb_rd  in  5  mem_wb_rd
- wb_regwrite  in  1  mem_wb_regwrite
- wb_halt  in  1  mem_wb_halt
- pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1 each  latch enables
- if_id_flush, id_ex_flush  out  1 each  load bubble (all controls zero) when enable is also 1
- forwardA, forwardB  out  2 each  00 register file, 10 MEM-stage result, 01 WB write data
- stall  out  1  any enable below full advance
- halt  out  1  registered; 1 in HALTED
- drain_err  out  1  registered, sticky until RST
- stall_cnt  out  CNT_W  stall cycles since reset

Behaviour:
- Reset (RST=1 at a CLK edge): state RUN, halt=0, drain_err=0, stall_cnt=0, drain counter=0. Reset mid-drain or in HALTED returns to RUN.
- States:
  - RUN to DRAIN: id_halt=1 and ID/EX advances this cycle.
  - DRAIN to HALTED: wb_halt=1, or drain counter reaches DRAIN_MAX (also sets drain_err).
  - HALTED is absorbing until RST.
- Definitions:
  - dwait = mem_dreq & ~dhit
  - loaduse = ex_load & ex_rd!=0 & ((id_use1 & id_rs1==ex_rd) | (id_use2 & id_rs2==ex_rd))
- Combinational enables, first match wins:
  1. HALTED: all writes 0, flushes 0.
  2. dwait: all writes 0; whole pipe frozen; no flush.
  3. ex_redirect: all writes 1; if_id_flush=1, id_ex_flush=1. PC loads the target even if ihit=0; the outstanding fetch is discarded.
  4. loaduse: pc_write=0, if_id_write=0; id_ex_write=1 with id_ex_flush=1; EX/MEM and MEM/WB advance. Exactly one stall cycle per load-use; the consumer later forwards 01.
  5. DRAIN, or ~ihit: pc_write=0; if_id_write=1 with if_id_flush=1; the rest advance.
  6. Otherwise: all writes 1, no flush.
- Redirect in DRAIN is ignored for the PC: pc_write stays 0 and the flushes still apply.
- Forwarding (combinational, per operand rsX):
  - 10 if mem_regwrite & mem_rd!=0 & mem_rd==rsX.
  - Else 01 if wb_regwrite & wb_rd!=0 & wb_rd==rsX.
  - Else 00. MEM has priority over WB.
- stall = ~(all writes 1 and no flush).
- stall_cnt increments each cycle with stall=1 in RUN or DRAIN; saturates; frozen in HALTED.
- Drain counter: clears on entry to DRAIN, increments each DRAIN cycle.
- halt asserts the cycle after the transition into HALTED.

Decomposition:
- cpu_types_pkg gains:
  - hz_state_t enum {RUN, DRAIN, HALTED}
  - fwd_sel_t (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10)
  - HZ_DRAIN_MAX default
- One sub-module, forward_unit: purely combinational, instantiated twice (A, B). FSM, priority logic and counters stay in the top.

Test Plan:
- Load-use: ex_load=1, ex_rd=5, id_rs1=5, id_use1=1, ihit=1 gives one cycle of pc_write=0, if_id_write=0, id_ex_flush=1, stall=1, stall_cnt 0 to 1. Next cycle: wb_rd=5, wb_regwrite=1, ex_rs1=5 gives forwardA=01.
- Forward priority: mem_rd=wb_rd=ex_rs2=7, both regwrite=1 gives forwardB=10. With rd=0 in both gives 00.
- dwait over redirect: mem_dreq=1, dhit=0, ex_redirect=1 for 3 cycles gives all writes 0 and no flush. On dhit=1: if_id_flush=1, id_ex_flush=1, pc_write=1.
- ihit=0 for 2 cycles gives pc_write=0 and if_id_flush=1 each cycle, stall_cnt=2. With ex_redirect=1 in cycle 2, pc_write=1 in that cycle.
- Halt: id_halt=1, then wb_halt=1 three cycles later. During DRAIN, pc_write=0 and if_id_flush=1. halt=1 from the cycle after wb_halt, all writes 0 after. RST=1 gives halt=0 and state RUN.
- Drain timeout: id_halt=1 with wb_halt never asserted gives HALTED after 7 DRAIN cycles, drain_err=1, stall_cnt then constant.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the hazard/sequencing logic: controller states,
// forwarding mux selects, default sizing and a register-match helper.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam int HZ_DRAIN_MAX = 7;
  localparam int HZ_CNT_W     = 32;

  // x0 is hardwired to zero, so a write to it never produces a usable value.
  function automatic logic srcMatches(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Operand bypass select for one EX-stage source register. The MEM-stage
// result is newer than the WB write data, so it wins when both match.
module forward_unit
  import cpu_types_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_memRd,
  input  logic       i_memRegWrite,
  input  logic [4:0] i_wbRd,
  input  logic       i_wbRegWrite,
  output fwd_sel_t   o_sel
);

  // Pick the youngest in-flight producer of the operand, else the register file.
  always_comb begin
    o_sel = FWD_RF;
    if (i_memRegWrite && srcMatches(i_memRd, i_rs)) begin
      o_sel = FWD_MEM;
    end else if (i_wbRegWrite && srcMatches(i_wbRd, i_rs)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Central hazard controller for the 5-stage pipeline: latch enables and
// bubble injection, operand forwarding, halt drain sequencing and a
// saturating stall-cycle counter.
module hazard_sequencer
  import cpu_types_pkg::*;
#(
  parameter int CNT_W     = HZ_CNT_W,
  parameter int DRAIN_MAX = HZ_DRAIN_MAX
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dreq,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             id_halt,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_load,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  input  logic             wb_halt,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             stall,
  output logic             halt,
  output logic             drain_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DCW = $clog2(DRAIN_MAX + 1);
  // The counter holds the number of DRAIN cycles already completed, so the
  // cycle that sees DRAIN_MAX-1 is the last one allowed.
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_MAX - 1);

  hz_state_t      r_state;
  hz_state_t      w_nextState;
  logic [DCW-1:0] r_drainCnt;
  logic           w_dWait;
  logic           w_loadUse;
  logic           w_idExAdvance;
  logic           w_drainTimeout;
  fwd_sel_t       w_fwdA;
  fwd_sel_t       w_fwdB;

  assign w_dWait   = mem_dreq & ~dhit;
  assign w_loadUse = ex_load & ((id_use1 & srcMatches(ex_rd, id_rs1)) |
                                (id_use2 & srcMatches(ex_rd, id_rs2)));

  // Latch enables and bubbles, resolved in strict priority order.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    if (r_state == HALTED || w_dWait) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
    end else if (ex_redirect) begin
      pc_write    = (r_state != DRAIN);
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_loadUse) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else if (r_state == DRAIN || !ihit) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  assign stall = ~(pc_write & if_id_write & id_ex_write & ex_mem_write &
                   mem_wb_write & ~if_id_flush & ~id_ex_flush);

  // A real instruction leaves ID only when ID/EX loads without a bubble.
  assign w_idExAdvance = id_ex_write & ~id_ex_flush;

  // Halt sequencing: leave RUN once HALT is in EX, stop when it retires or times out.
  always_comb begin
    w_nextState    = r_state;
    w_drainTimeout = 1'b0;
    case (r_state)
      RUN: begin
        if (id_halt && w_idExAdvance) w_nextState = DRAIN;
      end
      DRAIN: begin
        if (wb_halt) begin
          w_nextState = HALTED;
        end else if (r_drainCnt >= DRAIN_LAST) begin
          w_nextState    = HALTED;
          w_drainTimeout = 1'b1;
        end
      end
      HALTED:  w_nextState = HALTED;
      default: w_nextState = RUN;
    endcase
  end

  // State register with registered halt flag and sticky drain error.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= RUN;
      halt      <= 1'b0;
      drain_err <= 1'b0;
    end else begin
      r_state <= w_nextState;
      halt    <= (w_nextState == HALTED);
      if (w_drainTimeout) drain_err <= 1'b1;
    end
  end

  // Counts DRAIN cycles so a HALT that never retires cannot hang the core.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_drainCnt <= '0;
    end else if (r_state == RUN && w_nextState == DRAIN) begin
      r_drainCnt <= '0;
    end else if (r_state == DRAIN) begin
      r_drainCnt <= r_drainCnt + DCW'(1);
    end
  end

  // Saturating stall-cycle counter, frozen once the core has halted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (r_state != HALTED && stall && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  forward_unit u_fwdA (
    .i_rs          (ex_rs1),
    .i_memRd       (mem_rd),
    .i_memRegWrite (mem_regwrite),
    .i_wbRd        (wb_rd),
    .i_wbRegWrite  (wb_regwrite),
    .o_sel         (w_fwdA)
  );

  forward_unit u_fwdB (
    .i_rs          (ex_rs2),
    .i_memRd       (mem_rd),
    .i_memRegWrite (mem_regwrite),
    .i_wbRd        (wb_rd),
    .i_wbRegWrite  (wb_regwrite),
    .o_sel         (w_fwdB)
  );

  assign forwardA = w_fwdA;
  assign forwardB = w_fwdB;

endmodule
